// File: rtl/uart_word_assembler.sv
// uart_word_assembler: rebuilds N_BIT-wide words from received UART bytes (MSB byte first) and writes them to a FIFO
// Ports: clk_i, reset_i (async, active-high); rx_valid_i/rx_data_i received-byte strobe and byte;
//   fifo_full_i downstream backpressure; clr_err_i clears overflow_o; wr_en_o/data_wr_o FIFO write strobe and word;
//   busy_o not idle; overflow_o sticky dropped-byte flag; timeout_err_o pulse when a partial word is discarded
module uart_word_assembler #(
   parameter int N_BIT       = 8,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             rx_valid_i,
   input  logic [7:0]       rx_data_i,
   input  logic             fifo_full_i,
   input  logic             clr_err_i,
   output logic             wr_en_o,
   output logic [N_BIT-1:0] data_wr_o,
   output logic             busy_o,
   output logic             overflow_o,
   output logic             timeout_err_o
);
   localparam int NB = (N_BIT + 7) / 8;
   localparam int CW = $clog2(NB + 1);
   localparam int TW = $clog2(TIMEOUT_CYC);
   typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_WRITE} state_t;
   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [NB*8-1:0]   shift_q, shift_d, shift_ins;
   logic [N_BIT-1:0]  data_q, data_d;
   logic              wr_q, wr_d, ovf_q, ovf_d, to_q, to_d;
   logic              last;
   // Byte k lands in slot NB-1-k, so the word is simply the top N_BIT bits;
   // the unused low bits of a partial last byte fall below the word.
   always_comb begin
      shift_ins = shift_q;
      for (int k = 0; k < NB; k++)
         if (cnt_q == CW'(k)) shift_ins[(NB-1-k)*8 +: 8] = rx_data_i;
   end
   // cnt_q is 0 in ST_IDLE, so a single-byte word completes straight from idle
   assign last = cnt_q == CW'(NB - 1);
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      timer_d = timer_q;
      shift_d = shift_q;
      data_d  = data_q;
      wr_d    = 1'b0;
      to_d    = 1'b0;
      ovf_d   = (state_q == ST_WRITE && rx_valid_i) || (ovf_q && !clr_err_i);
      case (state_q)
         ST_IDLE, ST_COLLECT:
            if (rx_valid_i) begin
               shift_d = shift_ins;
               timer_d = '0;
               cnt_d   = last ? '0 : cnt_q + 1'b1;
               state_d = last ? ST_WRITE : ST_COLLECT;
               data_d  = last ? shift_ins[NB*8-1 -: N_BIT] : data_q;
            end else if (state_q == ST_COLLECT) begin
               if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                  to_d    = 1'b1;
                  cnt_d   = '0;
                  timer_d = '0;
                  shift_d = '0;
                  state_d = ST_IDLE;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
         ST_WRITE:
            if (!fifo_full_i) begin
               wr_d    = 1'b1;
               state_d = ST_IDLE;
            end
         default: state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         timer_q <= '0;
         shift_q <= '0;
         data_q  <= '0;
         wr_q    <= 1'b0;
         ovf_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         timer_q <= timer_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         wr_q    <= wr_d;
         ovf_q   <= ovf_d;
         to_q    <= to_d;
      end
   end
   assign wr_en_o       = wr_q;
   assign data_wr_o     = data_q;
   assign busy_o        = state_q != ST_IDLE;
   assign overflow_o    = ovf_q;
   assign timeout_err_o = to_q;
endmodule

// File: tb/tb_uart_word_assembler.sv
// tb_uart_word_assembler: three word widths share one byte stream and are checked every cycle against a packing model
module tb_uart_word_assembler;
   localparam int TC = 16;
   localparam int NBITS [3] = '{8, 12, 24};
   logic clk = 1'b0, rst = 1'b1, rv = 1'b0, ff = 1'b0, ce = 1'b0;
   logic [7:0] rd = 8'h00;
   logic wr [3], bsy [3], ovf [3], tmo [3];
   logic [7:0] d8;
   logic [11:0] d12;
   logic [23:0] d24;
   logic [31:0] dat [3];
   int pass = 0, total = 0, wr8_cnt = 0, c0;
   int mode [3], got [3], idle [3];
   logic [7:0] mb [3][3];
   logic [31:0] e_data [3];
   logic e_wr [3], e_ovf [3], e_to [3];
   always #5 clk = ~clk;
   assign dat[0] = 32'(d8);
   assign dat[1] = 32'(d12);
   assign dat[2] = 32'(d24);
   uart_word_assembler #(.N_BIT(8), .TIMEOUT_CYC(TC)) u8 (
      .clk_i(clk), .reset_i(rst), .rx_valid_i(rv), .rx_data_i(rd), .fifo_full_i(ff), .clr_err_i(ce),
      .wr_en_o(wr[0]), .data_wr_o(d8), .busy_o(bsy[0]), .overflow_o(ovf[0]), .timeout_err_o(tmo[0]));
   uart_word_assembler #(.N_BIT(12), .TIMEOUT_CYC(TC)) u12 (
      .clk_i(clk), .reset_i(rst), .rx_valid_i(rv), .rx_data_i(rd), .fifo_full_i(ff), .clr_err_i(ce),
      .wr_en_o(wr[1]), .data_wr_o(d12), .busy_o(bsy[1]), .overflow_o(ovf[1]), .timeout_err_o(tmo[1]));
   uart_word_assembler #(.N_BIT(24), .TIMEOUT_CYC(TC)) u24 (
      .clk_i(clk), .reset_i(rst), .rx_valid_i(rv), .rx_data_i(rd), .fifo_full_i(ff), .clr_err_i(ce),
      .wr_en_o(wr[2]), .data_wr_o(d24), .busy_o(bsy[2]), .overflow_o(ovf[2]), .timeout_err_o(tmo[2]));
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask
   // word bit (N-1-b) is stream bit b, the stream being the bytes MSB-first
   function automatic logic [31:0] pack(input int i);
      logic [31:0] w;
      w = '0;
      for (int b = 0; b < NBITS[i]; b++) w[NBITS[i]-1-b] = mb[i][b/8][7-b%8];
      return w;
   endfunction
   initial forever begin
      @(posedge clk or posedge rst);
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            mode[i] = 0; got[i] = 0; idle[i] = 0;
            e_data[i] = '0; e_wr[i] = 1'b0; e_ovf[i] = 1'b0; e_to[i] = 1'b0;
         end else begin
            e_wr[i] = 1'b0;
            e_to[i] = 1'b0;
            if (mode[i] == 2 && rv) e_ovf[i] = 1'b1;
            else if (ce) e_ovf[i] = 1'b0;
            if (mode[i] == 2) begin
               if (!ff) begin e_wr[i] = 1'b1; mode[i] = 0; end
            end else if (rv) begin
               mb[i][got[i]] = rd;
               got[i]++;
               idle[i] = 0;
               mode[i] = 1;
               if (got[i] * 8 >= NBITS[i]) begin e_data[i] = pack(i); got[i] = 0; mode[i] = 2; end
            end else if (mode[i] == 1) begin
               idle[i]++;
               if (idle[i] == TC) begin e_to[i] = 1'b1; mode[i] = 0; got[i] = 0; end
            end
         end
      end
   end
   initial forever begin
      @(negedge clk);
      if (wr[0]) wr8_cnt++;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("u%0d.wr_en", NBITS[i]), 32'(wr[i]), 32'(e_wr[i]));
         chk($sformatf("u%0d.data_wr", NBITS[i]), dat[i], e_data[i]);
         chk($sformatf("u%0d.busy", NBITS[i]), 32'(bsy[i]), 32'(mode[i] != 0));
         chk($sformatf("u%0d.overflow", NBITS[i]), 32'(ovf[i]), 32'(e_ovf[i]));
         chk($sformatf("u%0d.timeout_err", NBITS[i]), 32'(tmo[i]), 32'(e_to[i]));
      end
   end
   task automatic tick();
      @(posedge clk);
      #3;
   endtask
   task automatic send(input logic [7:0] b, input int gap);
      rv = 1'b1;
      rd = b;
      tick();
      rv = 1'b0;
      rd = 8'($urandom);
      repeat (gap) tick();
   endtask
   initial begin
      repeat (3) tick();
      chk("reset.busy24", 32'(bsy[2]), 0);
      chk("reset.data12", dat[1], 0);
      rst = 1'b0;
      tick();
      send(8'hAB, 3); send(8'hCD, 3); send(8'hEF, 3);
      chk("abcdef.u24", dat[2], 32'hABCDEF);
      chk("abcdef.model24", e_data[2], 32'hABCDEF);
      chk("abcdef.u12", dat[1], 32'hABC);
      chk("abcdef.u8", dat[0], 32'hEF);
      repeat (20) tick();
      chk("timeout.u12.idle", 32'(bsy[1]), 0);
      send(8'h5A, 3); send(8'hF3, 3);
      chk("5af.u12", dat[1], 32'h5AF);
      chk("5af.model12", e_data[1], 32'h5AF);
      chk("5af.u8", dat[0], 32'hF3);
      repeat (20) tick();
      ff = 1'b1;
      tick();
      c0 = wr8_cnt;
      send(8'h7E, 2); send(8'h99, 2);
      chk("full.u8.ovf", 32'(ovf[0]), 1);
      chk("full.u8.busy", 32'(bsy[0]), 1);
      chk("full.u12", dat[1], 32'h7E9);
      repeat (4) tick();
      chk("full.u8.nowrite", 32'(wr8_cnt - c0), 0);
      ff = 1'b0;
      repeat (3) tick();
      chk("release.u8.onewrite", 32'(wr8_cnt - c0), 1);
      chk("release.u8.data", dat[0], 32'h7E);
      chk("release.model8", e_data[0], 32'h7E);
      chk("release.u8.idle", 32'(bsy[0]), 0);
      ce = 1'b1; tick(); ce = 1'b0;
      chk("clr.u8.ovf", 32'(ovf[0]), 0);
      repeat (20) tick();
      ff = 1'b1;
      send(8'h11, 2);
      rv = 1'b1; rd = 8'h22; ce = 1'b1;
      tick();
      rv = 1'b0; ce = 1'b0;
      chk("clrset.u8.ovf", 32'(ovf[0]), 1);
      ff = 1'b0;
      repeat (3) tick();
      chk("clrset.u8.data", dat[0], 32'h11);
      chk("clrset.u12.data", dat[1], 32'h112);
      repeat (20) tick();
      send(8'h01, 2);
      rst = 1'b1;
      tick();
      chk("midreset.u12.busy", 32'(bsy[1]), 0);
      chk("midreset.u12.data", dat[1], 0);
      chk("midreset.u8.ovf", 32'(ovf[0]), 0);
      tick();
      rst = 1'b0;
      tick();
      send(8'h01, 3); send(8'h02, 3);
      chk("after_reset.u12", dat[1], 32'h010);
      chk("after_reset.model12", e_data[1], 32'h010);
      chk("after_reset.u8", dat[0], 32'h02);
      repeat (20) tick();
      for (int c = 0; c < 3000; c++) begin
         rv = ($urandom % 4) == 0;
         rd = 8'($urandom);
         ce = ($urandom % 40) == 0;
         if ($urandom % 8 == 0) ff = ~ff;
         if ($urandom % 200 == 0) begin
            rv = 1'b0;
            repeat (20) tick();
         end
         if ($urandom % 900 == 0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end
         tick();
      end
      rv = 1'b0; ce = 1'b0; ff = 1'b0;
      repeat (3) tick();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
